dat_init_seq: RTL and testbench
===============================

DAT_INIT_SEQ -- requirements
Module: dat_init_seq

Interface
REQ-001 The module SHALL have one parameter: TASK_LAST, default 12'hFFF, meaning the highest task number filled, inclusive.
REQ-002 The module SHALL have the following ports, one per line as name, direction, width, meaning:
- e  input  1  the sole clock, the CPU E clock; all state SHALL update on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to re-run the fill, decoded by the MMU register logic.
- dat_gnt  input  1  the arbiter grants the DAT RAM port to this block this cycle.
- dat_rdata  input  16  DAT RAM read data, valid in the same cycle as dat_addr.
- dat_req  output  1  the block requests the DAT RAM port.
- dat_addr  output  15  DAT RAM address, {task[11:0], slot[2:0]}.
- dat_wdata  output  16  DAT RAM write data.
- dat_we_l  output  1  active-high write strobe, low byte.
- dat_we_h  output  1  active-high write strobe, high byte.
- busy  output  1  a fill or verify pass is in progress; the MMU SHALL treat the DAT as invalid.
- done  output  1  one-cycle pulse when a pass completes.
- err  output  1  sticky verify mismatch flag.
- err_addr  output  15  address of the first mismatch.

Function
REQ-003 The block SHALL implement the states IDLE, FILL, VERIFY and DONE.
REQ-004 In FILL, dat_req SHALL be 1, and dat_we_l and dat_we_h SHALL equal dat_gnt (combinational).
REQ-005 The fill value SHALL be dat_wdata = {8'h00, 5'b00000, slot}, i.e. an identity map: bank = slot (<8), which passes through to the board.
REQ-006 The address counter SHALL advance by 1 only on cycles with dat_gnt=1; with dat_gnt=0 the address and outputs SHALL hold and no write SHALL occur.
REQ-007 The counter SHALL start at 15'h0000 and the fill SHALL end after writing {TASK_LAST, 3'b111}.
REQ-008 On that final granted write, the next state SHALL be VERIFY if DAT_VERIFY_EN is defined, otherwise DONE; the counter SHALL reset to 0.
REQ-009 A fill of N = (TASK_LAST+1)*8 entries SHALL take exactly N granted cycles.
REQ-010 DONE SHALL last one cycle, assert done=1, and then go to IDLE.
REQ-011 In IDLE: dat_req=0, busy=0, strobes=0, dat_addr=0.
REQ-012 start=1 in IDLE SHALL enter FILL on the next edge and clear err and err_addr.
REQ-013 start SHALL be ignored in FILL, VERIFY and DONE; no queueing.
REQ-014 busy SHALL be 1 in FILL and VERIFY and 0 in IDLE and DONE.
REQ-015 The counter SHALL never exceed {TASK_LAST, 3'b111}; there SHALL be no wrap-around into unfilled tasks.

Reset
REQ-016 When reset=1 at a rising edge: state=FILL, counter=0, err=0, err_addr=0, done=0.
REQ-017 The block SHALL therefore auto-fill after every reset; reset asserted mid-fill or mid-verify SHALL restart at address 0.
REQ-018 Reset outputs: dat_req=1, busy=1, strobes=0 until dat_gnt is seen.

Configuration
REQ-019 With macro DAT_VERIFY_EN defined, the VERIFY state SHALL exist.
REQ-020 In VERIFY: dat_req=1 and strobes=0; each granted cycle SHALL compare dat_rdata with the expected fill value for dat_addr.
REQ-021 On the first mismatch in VERIFY, err SHALL be set and err_addr SHALL capture dat_addr; later mismatches SHALL leave err_addr unchanged.
REQ-022 VERIFY SHALL advance and end exactly as FILL does, then go to DONE.
REQ-023 Without DAT_VERIFY_EN: no VERIFY state, err tied 0, err_addr tied 0, dat_rdata unused.

Structure
REQ-024 A shared package dat_pkg SHALL hold the state encoding, the DAT address width (15), the data width (16), and the fill-value function of slot.
REQ-025 The address counter with grant-gated increment and terminal-count flag SHALL be a sub-module, dat_fill_counter.

Verification
REQ-026 Reset, TASK_LAST=12'h001, dat_gnt held 1 -> 16 writes at addresses 0..15 with low bytes 0..7 repeating, done pulse on cycle 17, then IDLE.
REQ-027 dat_gnt toggled 1,0,1,0 mid-fill -> address held and no strobe on grant-low cycles; total write count still 16.
REQ-028 start pulsed during FILL at address 5 -> ignored, no restart; start in IDLE -> FILL from address 0.
REQ-029 reset asserted at address 9 -> next cycle address 0, busy=1.
REQ-030 DAT_VERIFY_EN defined, model forces dat_rdata=16'h0005 at addresses 3 and 10 -> err=1, err_addr=15'h0003.
REQ-031 Default TASK_LAST, gnt always 1 -> done exactly 32769 cycles after reset release (non-verify build).

Source files
------------

// File: rtl/dat_pkg.sv
// Shared definitions for the DAT initialisation sequencer: state encoding,
// address/data widths and the identity fill value (bank = slot).
package dat_pkg;

  localparam int DAT_AW = 15;
  localparam int DAT_DW = 16;
  localparam int TASK_W = 12;
  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } dat_state_e;

  function automatic logic [DAT_DW-1:0] fill_value(input logic [SLOT_W-1:0] slot);
    return {8'h00, 5'b00000, slot};
  endfunction

endpackage

// File: rtl/dat_fill_counter.sv
// DAT address counter: grant-gated increment, synchronous clear, and a
// terminal-count flag at {TASK_LAST, 3'b111}; wraps to 0 only on the final step.
module dat_fill_counter
  import dat_pkg::*;
#(
  parameter logic [TASK_W-1:0] TASK_LAST = 12'hFFF
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [DAT_AW-1:0] addr_o,
  output logic              tc_o
);

  localparam logic [DAT_AW-1:0] LAST_ADDR = {TASK_LAST, 3'b111};

  logic [DAT_AW-1:0] addr_q;
  logic [DAT_AW-1:0] addr_d;

  // Address register.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
  end

  // Next address: clear wins, terminal step returns to 0 so the count never runs past the last task.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = {DAT_AW{1'b0}};
    end else if (inc_i) begin
      if (tc_o) begin
        addr_d = {DAT_AW{1'b0}};
      end else begin
        addr_d = addr_q + 15'd1;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  assign tc_o   = (addr_q == LAST_ADDR);
  assign addr_o = addr_q;

endmodule

// File: rtl/dat_init_seq.sv
// DAT RAM initialisation sequencer: fills every {task, slot} entry with the
// identity bank map after reset or on request. Optional read-back check: DAT_VERIFY_EN.
module dat_init_seq
  import dat_pkg::*;
#(
  parameter logic [TASK_W-1:0] TASK_LAST = 12'hFFF
) (
  input  logic              e,
  input  logic              reset,
  input  logic              start,
  input  logic              dat_gnt,
  input  logic [DAT_DW-1:0] dat_rdata,
  output logic              dat_req,
  output logic [DAT_AW-1:0] dat_addr,
  output logic [DAT_DW-1:0] dat_wdata,
  output logic              dat_we_l,
  output logic              dat_we_h,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DAT_AW-1:0] err_addr
);

  dat_state_e        state_q;
  dat_state_e        state_d;
  logic [DAT_AW-1:0] cnt_s;
  logic              tc_s;
  logic              cnt_inc_s;
  logic              cnt_clr_s;
  logic              start_clr_s;
  logic              chk_s;
  logic              we_s;
  logic              busy_s;

  dat_fill_counter #(
    .TASK_LAST (TASK_LAST)
  ) u_cnt (
    .clk_i  (e),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .addr_o (cnt_s),
    .tc_o   (tc_s)
  );

  // State register; reset lands in FILL so the table is rebuilt after every reset.
  always_ff @(posedge e) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d     = state_q;
    dat_req     = 1'b0;
    we_s        = 1'b0;
    busy_s      = 1'b0;
    done        = 1'b0;
    cnt_inc_s   = 1'b0;
    start_clr_s = 1'b0;
    chk_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FILL;
          start_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        dat_req   = 1'b1;
        busy_s    = 1'b1;
        we_s      = dat_gnt;
        cnt_inc_s = dat_gnt;
        if (dat_gnt && tc_s) begin
`ifdef DAT_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_FILL;
        end
      end
`ifdef DAT_VERIFY_EN
      ST_VERIFY: begin
        dat_req   = 1'b1;
        busy_s    = 1'b1;
        cnt_inc_s = dat_gnt;
        chk_s     = dat_gnt;
        if (dat_gnt && tc_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_VERIFY;
        end
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cnt_clr_s = reset | start_clr_s;
  assign busy      = busy_s;
  assign dat_we_l  = we_s;
  assign dat_we_h  = we_s;
  assign dat_addr  = busy_s ? cnt_s : {DAT_AW{1'b0}};
  assign dat_wdata = fill_value(cnt_s[SLOT_W-1:0]);

`ifdef DAT_VERIFY_EN
  logic              err_q;
  logic              err_d;
  logic [DAT_AW-1:0] err_addr_q;
  logic [DAT_AW-1:0] err_addr_d;
  logic              mism_s;

  assign mism_s = (dat_rdata != fill_value(cnt_s[SLOT_W-1:0]));

  // Sticky error flag and first-mismatch address.
  always_ff @(posedge e) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= {DAT_AW{1'b0}};
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Only the first mismatch of a pass is captured; a new start clears the record.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (start_clr_s) begin
      err_d      = 1'b0;
      err_addr_d = {DAT_AW{1'b0}};
    end else if (chk_s && mism_s && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = cnt_s;
    end else begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_s;
  assign unused_s = ^{dat_rdata, chk_s};
  assign err      = 1'b0;
  assign err_addr = {DAT_AW{1'b0}};
`endif

endmodule

// File: tb/tb_dat_init_seq.sv
// Self-checking bench for dat_init_seq: a small instance (TASK_LAST=1) checked
// every cycle against a pass-level model, plus a default-size instance for timing.
module tb_dat_init_seq;

`ifdef DAT_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  localparam int N0   = 16;
  localparam int EXP0 = VER ? 33 : 17;
  localparam int EXP1 = VER ? 65537 : 32769;

  logic e = 1'b0;
  always #5 e = ~e;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Instance 0: small table
  logic        rst0, start0, gnt0, req0, wel0, weh0, busy0, done0, err0;
  logic [15:0] rdata0, wdata0;
  logic [14:0] addr0, eaddr0;
  logic        force_bad;
  logic [15:0] mem [0:15];

  dat_init_seq #(.TASK_LAST(12'h001)) u0 (
    .e(e), .reset(rst0), .start(start0), .dat_gnt(gnt0), .dat_rdata(rdata0),
    .dat_req(req0), .dat_addr(addr0), .dat_wdata(wdata0), .dat_we_l(wel0),
    .dat_we_h(weh0), .busy(busy0), .done(done0), .err(err0), .err_addr(eaddr0)
  );

  // RAM model, with optional corruption of reads at addresses 3 and 10
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
  always @(posedge e) if (wel0 && weh0) mem[addr0[3:0]] <= wdata0;
  assign rdata0 = (force_bad && (addr0 == 15'd3 || addr0 == 15'd10)) ? 16'h0005 : mem[addr0[3:0]];

  int wr_cnt = 0;
  always @(posedge e) if (wel0 && weh0) wr_cnt <= wr_cnt + 1;

  // Pass-level model: mode -1 unknown, 0 idle, 1 fill, 2 verify, 3 done
  int m_mode = -1;
  int m_idx  = 0;
  int m_err  = 0;
  int m_eadr = 0;

  always @(posedge e) begin
    if (rst0) begin
      m_mode = 1; m_idx = 0; m_err = 0; m_eadr = 0;
    end else begin
      case (m_mode)
        0: if (start0) begin m_mode = 1; m_idx = 0; m_err = 0; m_eadr = 0; end
        1, 2: if (gnt0) begin
          if (m_mode == 2 && int'(rdata0) != (m_idx % 8) && m_err == 0) begin
            m_err = 1; m_eadr = m_idx;
          end
          if (m_idx == N0 - 1) begin
            m_idx  = 0;
            m_mode = (m_mode == 1 && VER) ? 2 : 3;
          end else begin
            m_idx++;
          end
        end
        3: m_mode = 0;
        default: ;
      endcase
    end
  end

  always @(negedge e) begin
    if (m_mode >= 0) begin
      chk("req", req0, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("busy", busy0, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("addr", addr0, (m_mode == 1 || m_mode == 2) ? m_idx : 0);
      chk("we_l", wel0, (m_mode == 1 && gnt0) ? 1 : 0);
      chk("we_h", weh0, (m_mode == 1 && gnt0) ? 1 : 0);
      chk("done", done0, (m_mode == 3) ? 1 : 0);
      chk("err", err0, m_err);
      chk("err_addr", eaddr0, m_eadr);
      if (m_mode == 1) chk("wdata", wdata0, m_idx % 8);
    end
  end

  // Instance 1: default TASK_LAST, grant always high
  logic        rst1, req1, wel1, weh1, busy1, done1, err1;
  logic [15:0] rdata1, wdata1;
  logic [14:0] addr1, eaddr1;
  logic        rel = 1'b0;
  logic        fin1 = 1'b0;

  dat_init_seq u1 (
    .e(e), .reset(rst1), .start(1'b0), .dat_gnt(1'b1), .dat_rdata(rdata1),
    .dat_req(req1), .dat_addr(addr1), .dat_wdata(wdata1), .dat_we_l(wel1),
    .dat_we_h(weh1), .busy(busy1), .done(done1), .err(err1), .err_addr(eaddr1)
  );
  assign rdata1 = {13'b0, addr1[2:0]};

  initial begin
    int early;
    early = 0;
    wait (rel);
    for (int k = 1; k <= EXP1 + 1; k++) begin
      @(negedge e);
      if (k < EXP1 && done1) early++;
      if (k == 1) begin
        chk("i1_first_addr", addr1, 0);
        chk("i1_first_busy", busy1, 1);
      end
      if (k == EXP1 - 1) begin
        chk("i1_last_addr", addr1, 32767);
        chk("i1_last_busy", busy1, 1);
      end
      if (k == EXP1) begin
        chk("i1_done", done1, 1);
        chk("i1_done_busy", busy1, 0);
      end
      if (k == EXP1 + 1) begin
        chk("i1_idle_done", done1, 0);
        chk("i1_idle_req", req1, 0);
        chk("i1_idle_addr", addr1, 0);
        chk("i1_err", err1, 0);
      end
    end
    chk("i1_early_done", early, 0);
    fin1 = 1'b1;
  end

  task automatic tick();
    @(posedge e);
    #2;
  endtask

  task automatic run_to_done(input string nm, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge e);
      if (done0) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) chk({nm, "_timeout"}, 0, 1);
    tick();
  endtask

  task automatic pulse_start();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    int w0;
    int cyc;
    rst0 = 1'b1; start0 = 1'b0; gnt0 = 1'b1; force_bad = 1'b0; rst1 = 1'b1;
    tick();
    tick();
    w0 = wr_cnt;
    rst0 = 1'b0; rst1 = 1'b0; rel = 1'b1;

    // Reset auto-fill with grant held
    run_to_done("t1", cyc);
    chk("t1_done_cycle", cyc, EXP0);
    chk("t1_writes", wr_cnt - w0, 16);
    @(negedge e);
    chk("t1_idle_busy", busy0, 0);
    chk("t1_idle_addr", addr0, 0);
    tick();

    // Start from IDLE, then grant toggling
    pulse_start();
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      gnt0 = (i % 2 == 0);
      if (i == 0) begin
        @(negedge e);
        chk("t2_start_addr", addr0, 0);
        chk("t2_start_busy", busy0, 1);
      end
      if (i == 3) begin
        @(negedge e);
        chk("t2_hold_addr", addr0, 2);
        chk("t2_hold_we", wel0, 0);
      end
      tick();
    end
    gnt0 = 1'b1;
    run_to_done("t2", cyc);
    chk("t2_writes", wr_cnt - w0, 16);

    // Start during FILL is ignored
    pulse_start();
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) tick();
    start0 = 1'b1;
    @(negedge e);
    chk("t3_addr5", addr0, 5);
    tick();
    start0 = 1'b0;
    @(negedge e);
    chk("t3_no_restart", addr0, 6);
    run_to_done("t3", cyc);
    chk("t3_writes", wr_cnt - w0, 16);

    // Reset mid-fill restarts at 0
    pulse_start();
    for (int i = 0; i < 9; i++) tick();
    rst0 = 1'b1;
    @(negedge e);
    chk("t4_addr9", addr0, 9);
    tick();
    rst0 = 1'b0;
    @(negedge e);
    chk("t4_rst_addr", addr0, 0);
    chk("t4_rst_busy", busy0, 1);
    run_to_done("t4", cyc);

    // Corrupted read-back at addresses 3 and 10
    force_bad = 1'b1;
    pulse_start();
    run_to_done("t5", cyc);
    chk("t5_err", err0, VER ? 1 : 0);
    chk("t5_err_addr", eaddr0, VER ? 3 : 0);
    force_bad = 1'b0;
    pulse_start();
    @(negedge e);
    chk("t5_err_clr", err0, 0);
    run_to_done("t5b", cyc);
    chk("t5b_err", err0, 0);

    for (int k = 0; k < 70000 && !fin1; k++) @(negedge e);
    if (!fin1) chk("i1_timeout", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
